// File: rtl/beta_pkg.sv
// Shared Beta pipeline constants and the register-file clear FSM state type.
package beta_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned R_ZERO = 31;
    localparam int unsigned R_XP   = 30;
    localparam int unsigned R_SP   = 29;
    localparam int unsigned R_LP   = 28;
    localparam int unsigned R_BP   = 27;

    // Zero encoding for StClear so an uninitialised state comes up clearing.
    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port output select: hardwired zero, busy blanking, optional
// same-cycle write bypass (port B over port A), else the stored word.
module rf_bypass_mux #(
    parameter int unsigned DATA_W   = beta_pkg::DATA_W,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = beta_pkg::R_ZERO,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [AW-1:0]     ra_i,
    input  logic              busy_i,
    input  logic              we_a_i,
    input  logic [AW-1:0]     wa_a_i,
    input  logic [DATA_W-1:0] wd_a_i,
    input  logic              we_b_i,
    input  logic [AW-1:0]     wa_b_i,
    input  logic [DATA_W-1:0] wd_b_i,
    input  logic [DATA_W-1:0] stored_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

    // Priority select of the read result.
    always_comb begin
        rdata_o = '0;
        if (ra_i == ZeroIdx || busy_i) begin
            rdata_o = '0;
        end else if (BYPASS && we_b_i && wa_b_i == ra_i) begin
            rdata_o = wd_b_i;
        end else if (BYPASS && we_a_i && wa_a_i == ra_i) begin
            rdata_o = wd_a_i;
        end else begin
            rdata_o = stored_i;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports,
// sequential clear after reset, EXT_REG reloaded from ext_in every run cycle.
module regfile_mp #(
    parameter int unsigned DATA_W   = beta_pkg::DATA_W,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 3,
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned ZERO_REG = beta_pkg::R_ZERO,
    parameter int unsigned XP_REG   = beta_pkg::R_XP,
    parameter int unsigned EXT_REG  = 0,
    parameter int unsigned DISP_N   = 8,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  we_a,
    input  logic                  wasel_a,
    input  logic [AW-1:0]         wa_a,
    input  logic [DATA_W-1:0]     wd_a,
    input  logic                  we_b,
    input  logic [AW-1:0]         wa_b,
    input  logic [DATA_W-1:0]     wd_b,
    input  logic [DATA_W-1:0]     ext_in,
    output logic                  busy,
    output logic [DISP_N*4-1:0]   disp_data
);

    import beta_pkg::*;

    localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);
    localparam logic [AW-1:0] XpIdx   = AW'(XP_REG);
    localparam logic [AW-1:0] ExtIdx  = AW'(EXT_REG);
    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic [AW-1:0]     wa_a_eff;
    logic [DISP_N*4-1:0] disp_raw;

    assign busy     = (state_q == StClear) | reset;
    assign wa_a_eff = wasel_a ? XpIdx : wa_a;

    // Clear FSM state register; reset restarts the clear from index 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Clear walks one register per cycle and hands over to run after the last.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LastIdx) begin
                state_d = StRun;
            end
        end
    end

    // Storage next state: clear step, or arbitrated writes with ext_in on top.
    always_comb begin
        mem_d = mem_q;
        if (!reset) begin
            if (state_q == StClear) begin
                mem_d[clr_idx_q] = '0;
            end else begin
                if (we_a && wa_a_eff != ZeroIdx) begin
                    mem_d[wa_a_eff] = wd_a;
                end
                // Port B after port A so it wins on an address collision.
                if (we_b && wa_b != ZeroIdx) begin
                    mem_d[wa_b] = wd_b;
                end
                mem_d[ExtIdx] = ext_in;
            end
        end
    end

    // Storage array register.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    for (genvar g = 0; g < DISP_N; g++) begin : g_disp
        assign disp_raw[g*4 +: 4] = mem_q[g+1][3:0];
    end

    assign disp_data = busy ? '0 : disp_raw;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_bypass_mux #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_mux (
            .ra_i     (ra[k*AW +: AW]),
            .busy_i   (busy),
            .we_a_i   (we_a),
            .wa_a_i   (wa_a_eff),
            .wd_a_i   (wd_a),
            .we_b_i   (we_b),
            .wa_b_i   (wa_b),
            .wd_b_i   (wd_b),
            .stored_i (mem_q[ra[k*AW +: AW]]),
            .rdata_o  (rdata[k*DATA_W +: DATA_W])
        );
    end

endmodule
